env_follower: RTL and testbench
===============================

# env_follower

Envelope follower and gate detector for the synth audio path: the analysis counterpart of the ADSR envelope generator. It rectifies an incoming signed audio stream and tracks its level with programmable attack/release slew. It emits the level as a Q2.14 envelope in the same format the ADSR block produces, plus a hysteretic gate with one-cycle onset/offset pulses. The onset pulse can drive the generator's `start` input directly.

## Interface
- `DATA_WIDTH`, default 16: sample width; samples are signed Q1.15. Only 16 is supported.
- `clk`  in  1  system clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `sample_valid`  in  1  qualifies `sample`; one sample per high cycle.
- `sample`  in  DATA_WIDTH  signed audio sample, Q1.15.
- `attack_step`  in  32  Q1.31 level increment per valid sample while rising.
- `release_step`  in  32  Q1.31 level decrement per valid sample while falling.
- `on_threshold`  in  16  Q2.14 envelope level that opens the gate.
- `off_threshold`  in  16  Q2.14 envelope level below which hold starts; software guarantees `off_threshold <= on_threshold`.
- `hold_time`  in  32  number of valid samples the gate stays open after falling below `off_threshold`.
- `env`  out  16  tracked level, Q2.14.
- `gate`  out  1  high while a note is detected.
- `onset`  out  1  one-cycle pulse when the gate opens.
- `offset`  out  1  one-cycle pulse when the gate closes.
- `peak`  out  16  only with `ENV_FOLLOWER_PEAK_EN`; see Configuration.

## Operation
- Rectify: `mag = |sample|`. Saturate -32768 to 32767. Target `tgt = {1'b0, mag[14:0], 16'h0000}` (Q1.31).
- Level register `lvl` (Q1.31) updates only on `sample_valid`. Use 33-bit arithmetic.
  - If `tgt > lvl`: `lvl_next = min(lvl + attack_step, tgt)`.
  - If `tgt < lvl`: `lvl_next = max(lvl - release_step, tgt)`. Borrow clamps to `tgt`.
  - If `tgt == lvl`: `lvl_next = lvl`.
  - `attack_step = 0` or `release_step = 0` freezes motion in that direction.
- `env = {1'b0, lvl[31:17]}`.
- Gate FSM states: IDLE, OPEN, HOLD. It is evaluated only on `sample_valid` cycles, using `env_next = {1'b0, lvl_next[31:17]}`.
  - IDLE: if `env_next >= on_threshold`, go to OPEN, set `gate`, pulse `onset`.
  - OPEN: if `env_next < off_threshold`, go to HOLD and clear `hcnt`. Otherwise stay.
  - HOLD: checks in this priority order:
    1. If `env_next >= on_threshold`, go back to OPEN with no `onset` pulse.
    2. Else if `hcnt >= hold_time`, go to IDLE, clear `gate`, pulse `offset`.
    3. Else `hcnt++`.
  - `hold_time = 0` closes the gate on the first valid sample in HOLD that does not re-open it.
- `hcnt` is 32 bits and saturates at `0xFFFF_FFFF`; it never wraps.
- Threshold inputs are sampled every valid cycle. Changing them mid-note takes effect on the next valid sample.

## Timing
- All outputs are registered. Reset values: `env = 0`, `gate = 0`, `onset = 0`, `offset = 0`, `peak = 0`. Internal `lvl = 0`, `hcnt = 0`, state IDLE.
- Latency: `env`, `gate`, `onset` and `offset` reflect a sample on the cycle after the `sample_valid` cycle.
- `onset` and `offset` are high for exactly one cycle. They are never both high on the same cycle.
- With `sample_valid` low, all state holds and the pulses are low.
- Back-to-back `sample_valid` is supported at full clock rate.
- `reset_n` low at any edge, including mid-note, returns everything to reset values on that edge. No pulse is emitted.

## Configuration
- `ENV_FOLLOWER_PEAK_EN` defined:
  - Adds output `peak` (Q2.14), the maximum `env` since the last onset.
  - `peak` loads `env_next` on the onset cycle.
  - `peak` updates to `max(peak, env_next)` on valid samples while `gate` is high.
  - `peak` holds after the gate closes.
- Not defined: the `peak` port and its logic are absent, and all other behaviour is identical.

## Test plan
- Rise and onset: reset, then `sample = 0x4000` on every valid cycle, `attack_step = 0x0100_0000`, `on_threshold = 0x1000`.
  - `env` rises by `0x80` per sample.
  - `onset` pulses on the cycle after the 32nd sample, when `env = 0x1000`.
  - `env` settles at `0x2000` after 64 samples and then holds.
- Release and offset: from the settled state, `sample = 0`, `release_step = 0x0080_0000`, `off_threshold = 0x0800`, `hold_time = 10`.
  - HOLD is entered on the 97th sample (`env = 0x07C0`).
  - `offset` pulses after 10 further valid samples, and `gate` falls on the same cycle.
- Re-trigger in hold: during HOLD, drive `sample = 0x7FFF`.
  - Gate returns to OPEN with no `onset` pulse.
  - `gate` never drops.
- Saturation: single `sample = 0x8000` with `attack_step = 0xFFFF_FFFF`.
  - `env = 0x3FFF`, with no overflow or wrap.
- Gaps and reset: insert random `sample_valid` gaps during the rise; the result is identical to the gap-free run.
  - Assert `reset_n = 0` mid-HOLD: all outputs are 0 on the next cycle, with no `offset` pulse.
- Peak (macro on): samples `0x2000`, then `0x6000`, then `0x1000` with large steps.
  - `peak = 0x3000` and holds after `gate` closes.

Source files
------------

// File: rtl/env_follower.sv
// env_follower: envelope follower and hysteretic gate detector.
//
// Rectifies a signed Q1.15 audio stream and tracks its level in a Q1.31
// register. The level slews up by attack_step and down by release_step per
// valid sample, and never overshoots the rectified target. The level is
// presented as a Q2.14 envelope. A three-state gate (idle/open/hold) raises
// gate on crossing on_threshold. It starts a hold countdown on dropping below
// off_threshold and closes once hold_time further samples pass without
// re-opening. onset/offset are single-cycle pulses on gate open/close.
//
// Optional feature: define ENV_FOLLOWER_PEAK_EN to add the peak output, which
// is the maximum envelope seen since the last onset.
//
// Ports:
//   clk            system clock
//   reset_n        synchronous active-low reset
//   sample_valid   qualifies sample (one sample per high cycle)
//   sample         signed Q1.15 audio sample
//   attack_step    Q1.31 level increment per valid sample while rising
//   release_step   Q1.31 level decrement per valid sample while falling
//   on_threshold   Q2.14 envelope level that opens the gate
//   off_threshold  Q2.14 envelope level below which hold starts
//   hold_time      valid samples the gate stays open after falling below off
//   env            tracked level, Q2.14
//   gate           high while a note is detected
//   onset          one-cycle pulse when the gate opens
//   offset         one-cycle pulse when the gate closes
//   peak           (ENV_FOLLOWER_PEAK_EN only) max env since last onset, Q2.14
module env_follower #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sample_valid,
    input  logic [DATA_WIDTH-1:0] sample,
    input  logic [31:0]           attack_step,
    input  logic [31:0]           release_step,
    input  logic [15:0]           on_threshold,
    input  logic [15:0]           off_threshold,
    input  logic [31:0]           hold_time,
    output logic [15:0]           env,
    output logic                  gate,
    output logic                  onset,
    output logic                  offset
`ifdef ENV_FOLLOWER_PEAK_EN
    ,
    output logic [15:0]           peak
`endif
);

    localparam int unsigned LVL_W = 32;
    localparam int unsigned ENV_W = 16;
    localparam int unsigned MAG_W = 15;
    localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [LVL_W-1:0]      HCNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OPEN,
        ST_HOLD
    } state_t;

    state_t           state;
    logic [LVL_W-1:0] lvl;
    logic [LVL_W-1:0] hcnt;

    logic [MAG_W-1:0] mag_c;
    logic [LVL_W-1:0] tgt_c;
    logic [LVL_W:0]   sum_c;
    logic [LVL_W:0]   diff_c;
    logic [LVL_W-1:0] lvl_next_c;
    logic [ENV_W-1:0] env_next_c;

    // Rectify; the most negative sample saturates to full scale.
    always_comb begin
        mag_c = sample[MAG_W-1:0];
        if (sample == MOST_NEG) begin
            mag_c = '1;
        end else if (sample[DATA_WIDTH-1]) begin
            mag_c = MAG_W'(~sample + DATA_WIDTH'(1));
        end
    end

    assign tgt_c = {1'b0, mag_c, 16'h0000};

    // Slew toward target in 33 bits so neither carry nor borrow can wrap.
    always_comb begin
        sum_c      = {1'b0, lvl} + {1'b0, attack_step};
        diff_c     = {1'b0, lvl} - {1'b0, release_step};
        lvl_next_c = lvl;
        if (tgt_c > lvl) begin
            lvl_next_c = (sum_c > {1'b0, tgt_c}) ? tgt_c : sum_c[LVL_W-1:0];
        end else if (tgt_c < lvl) begin
            lvl_next_c = (diff_c[LVL_W] || (diff_c[LVL_W-1:0] < tgt_c))
                         ? tgt_c : diff_c[LVL_W-1:0];
        end
    end

    assign env_next_c = {1'b0, lvl_next_c[LVL_W-1:17]};
    assign env        = {1'b0, lvl[LVL_W-1:17]};

    // Level, gate state machine and pulses; everything advances on valid only.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            lvl    <= '0;
            hcnt   <= '0;
            gate   <= 1'b0;
            onset  <= 1'b0;
            offset <= 1'b0;
`ifdef ENV_FOLLOWER_PEAK_EN
            peak   <= '0;
`endif
        end else begin
            onset  <= 1'b0;
            offset <= 1'b0;
            if (sample_valid) begin
                lvl <= lvl_next_c;
`ifdef ENV_FOLLOWER_PEAK_EN
                // Onset reloads; otherwise track the running max while open.
                if ((state == ST_IDLE) && (env_next_c >= on_threshold)) begin
                    peak <= env_next_c;
                end else if (gate && (env_next_c > peak)) begin
                    peak <= env_next_c;
                end
`endif
                case (state)
                    ST_IDLE: begin
                        if (env_next_c >= on_threshold) begin
                            state <= ST_OPEN;
                            gate  <= 1'b1;
                            onset <= 1'b1;
                        end
                    end
                    ST_OPEN: begin
                        if (env_next_c < off_threshold) begin
                            state <= ST_HOLD;
                            hcnt  <= '0;
                        end
                    end
                    ST_HOLD: begin
                        // Re-opening takes priority over closing.
                        if (env_next_c >= on_threshold) begin
                            state <= ST_OPEN;
                        end else if (hcnt >= hold_time) begin
                            state  <= ST_IDLE;
                            gate   <= 1'b0;
                            offset <= 1'b1;
                        end else if (hcnt != HCNT_MAX) begin
                            hcnt <= hcnt + LVL_W'(1);
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        gate  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_env_follower.sv
module tb_env_follower;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sample_valid = 1'b0;
    logic [15:0] sample = '0;
    logic [31:0] attack_step = '0;
    logic [31:0] release_step = '0;
    logic [15:0] on_threshold = '0;
    logic [15:0] off_threshold = '0;
    logic [31:0] hold_time = '0;
    logic [15:0] env;
    logic        gate;
    logic        onset;
    logic        offset;
`ifdef ENV_FOLLOWER_PEAK_EN
    logic [15:0] peak;
`endif

    env_follower #(.DATA_WIDTH(16)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .sample_valid(sample_valid),
        .sample(sample),
        .attack_step(attack_step),
        .release_step(release_step),
        .on_threshold(on_threshold),
        .off_threshold(off_threshold),
        .hold_time(hold_time),
        .env(env),
        .gate(gate),
        .onset(onset),
        .offset(offset)
`ifdef ENV_FOLLOWER_PEAK_EN
        ,
        .peak(peak)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    typedef struct {
        int env;
        bit gate;
        bit onset;
        bit offset;
        int peak;
    } exp_t;

    exp_t exp_q[$];

    // Parameters applied together with the next driven sample.
    longint c_atk, c_rel, c_hold;
    int     c_on, c_off;

    // Reference model: level as a plain integer, gate as open/holding flags.
    longint m_lvl = 0;
    longint m_hcnt = 0;
    bit     m_gate = 0;
    bit     m_holding = 0;
    int     m_peak = 0;

    function automatic void chk(input string nm, input longint act, input longint want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, want, $time);
        end
    endfunction

    function automatic exp_t model_step(input bit v, input logic [15:0] s, input bit rst);
        exp_t e;
        int sv, mag, envn;
        longint tgt;
        bit was_open;
        e.onset = 0;
        e.offset = 0;
        if (rst) begin
            m_lvl = 0; m_hcnt = 0; m_gate = 0; m_holding = 0; m_peak = 0;
        end else if (v) begin
            sv = int'($signed(s));
            if (sv == -32768) mag = 32767;
            else if (sv < 0) mag = -sv;
            else mag = sv;
            tgt = longint'(mag) * 65536;
            if (tgt > m_lvl) m_lvl = (m_lvl + c_atk > tgt) ? tgt : m_lvl + c_atk;
            else if (tgt < m_lvl) m_lvl = (m_lvl - c_rel < tgt) ? tgt : m_lvl - c_rel;
            envn = int'(m_lvl / 131072);
            was_open = m_gate;
            if (!m_gate) begin
                if (envn >= c_on) begin
                    m_gate = 1; m_holding = 0; e.onset = 1;
                end
            end else if (!m_holding) begin
                if (envn < c_off) begin
                    m_holding = 1; m_hcnt = 0;
                end
            end else begin
                if (envn >= c_on) m_holding = 0;
                else if (m_hcnt >= c_hold) begin
                    m_gate = 0; m_holding = 0; e.offset = 1;
                end else if (m_hcnt < 64'hFFFF_FFFF) m_hcnt++;
            end
            if (e.onset) m_peak = envn;
            else if (was_open && envn > m_peak) m_peak = envn;
        end
        e.env = int'(m_lvl / 131072);
        e.gate = m_gate;
        e.peak = m_peak;
        return e;
    endfunction

    // Drive one cycle of stimulus and queue the response it must produce.
    task automatic drive(input bit v, input logic [15:0] s, input bit rst);
        @(negedge clk);
        reset_n = !rst;
        sample_valid = v;
        sample = s;
        attack_step = 32'(c_atk);
        release_step = 32'(c_rel);
        on_threshold = 16'(c_on);
        off_threshold = 16'(c_off);
        hold_time = 32'(c_hold);
        exp_q.push_back(model_step(v, s, rst));
    endtask

    // Land just after the edge that applied the last driven cycle.
    task automatic wait_out;
        @(posedge clk);
        #2;
    endtask

    // Scoreboard monitor: one expected entry per clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_env", longint'(env), longint'(e.env));
                chk("sb_gate", longint'(gate), longint'(e.gate));
                chk("sb_onset", longint'(onset), longint'(e.onset));
                chk("sb_offset", longint'(offset), longint'(e.offset));
`ifdef ENV_FOLLOWER_PEAK_EN
                chk("sb_peak", longint'(peak), longint'(e.peak));
`endif
            end
        end
    end

    task automatic set_rise;
        c_atk = 64'h0100_0000; c_rel = 64'h0080_0000;
        c_on = 'h1000; c_off = 'h0800; c_hold = 10;
    endtask

    task automatic do_reset;
        for (int i = 0; i < 3; i++) drive(1'b1, 16'h4000, 1'b1);
        drive(1'b0, 16'h0, 1'b0);
    endtask

    task automatic run_to_hold(input logic [15:0] rise_s);
        int n;
        n = 0;
        while (!m_gate && n < 300) begin drive(1'b1, rise_s, 1'b0); n++; end
        n = 0;
        while (!m_holding && n < 600) begin drive(1'b1, 16'h0, 1'b0); n++; end
        chk("reach_hold", longint'(m_holding), 1);
    endtask

    initial begin
        int n, gaps;
        c_atk = 0; c_rel = 0; c_on = 0; c_off = 0; c_hold = 0;
        do_reset();
        wait_out();
        chk("reset_env", longint'(env), 0);
        chk("reset_gate", longint'(gate), 0);

        // Rise and onset.
        set_rise();
        for (int i = 1; i <= 70; i++) begin
            drive(1'b1, 16'h4000, 1'b0);
            if (i == 1) begin wait_out(); chk("rise_first", longint'(env), 'h80); end
            if (i == 31) begin wait_out(); chk("no_early_onset", longint'(onset), 0); end
            if (i == 32) begin
                wait_out();
                chk("onset_at_32", longint'(onset), 1);
                chk("env_at_32", longint'(env), 'h1000);
            end
            if (i == 64) begin wait_out(); chk("settle_64", longint'(env), 'h2000); end
        end
        wait_out();
        chk("settle_hold", longint'(env), 'h2000);

        // Release into hold, then close after the hold count.
        for (int i = 1; i <= 97; i++) begin
            drive(1'b1, 16'h0, 1'b0);
            if (i == 96) begin wait_out(); chk("pre_hold_env", longint'(env), 'h0800); end
        end
        wait_out();
        chk("hold_entry_env", longint'(env), 'h07C0);
        for (int i = 1; i <= 11; i++) begin
            drive(1'b1, 16'h0, 1'b0);
            wait_out();
            chk("offset_timing", longint'(offset), longint'(i == 11));
            chk("gate_timing", longint'(gate), longint'(i != 11));
        end

        // Re-trigger while holding: gate stays high, no onset.
        run_to_hold(16'h4000);
        c_atk = 64'h1000_0000;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 16'h7FFF, 1'b0);
            wait_out();
            chk("retrig_gate", longint'(gate), 1);
            chk("retrig_onset", longint'(onset), 0);
        end

        // Saturation of the most negative sample.
        do_reset();
        c_atk = 64'hFFFF_FFFF;
        drive(1'b1, 16'h8000, 1'b0);
        wait_out();
        chk("sat_env", longint'(env), 'h3FFF);
        drive(1'b1, 16'h8000, 1'b0);
        wait_out();
        chk("sat_env_hold", longint'(env), 'h3FFF);

        // Rise with random valid gaps matches the gap-free result.
        do_reset();
        set_rise();
        n = 0;
        while (n < 64) begin
            gaps = int'($urandom_range(0, 2));
            for (int g = 0; g < gaps; g++) drive(1'b0, 16'($urandom), 1'b0);
            drive(1'b1, 16'h4000, 1'b0);
            n++;
        end
        wait_out();
        chk("gaps_env", longint'(env), 'h2000);
        chk("gaps_gate", longint'(gate), 1);

        // Reset mid-hold: everything zero, no offset pulse.
        run_to_hold(16'h4000);
        drive(1'b1, 16'h0, 1'b0);
        drive(1'b1, 16'h0, 1'b1);
        wait_out();
        chk("rst_hold_env", longint'(env), 0);
        chk("rst_hold_gate", longint'(gate), 0);
        chk("rst_hold_offset", longint'(offset), 0);
        drive(1'b0, 16'h0, 1'b0);

`ifdef ENV_FOLLOWER_PEAK_EN
        // Peak tracking across a note and after it closes.
        do_reset();
        c_atk = 64'hFFFF_FFFF; c_rel = 64'hFFFF_FFFF;
        c_on = 'h0800; c_off = 'h0800; c_hold = 0;
        drive(1'b1, 16'h2000, 1'b0);
        drive(1'b1, 16'h6000, 1'b0);
        drive(1'b1, 16'h1000, 1'b0);
        drive(1'b1, 16'h0000, 1'b0);
        drive(1'b1, 16'h0000, 1'b0);
        wait_out();
        chk("peak_value", longint'(peak), 'h3000);
        chk("peak_gate_closed", longint'(gate), 0);
        drive(1'b1, 16'h0000, 1'b0);
        wait_out();
        chk("peak_holds", longint'(peak), 'h3000);
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int blk = 0; blk < 10; blk++) begin
            c_atk = longint'($urandom >> $urandom_range(0, 31));
            c_rel = longint'($urandom >> $urandom_range(0, 31));
            c_on = int'($urandom_range(0, 'h3FFF));
            c_off = int'($urandom_range(0, c_on));
            c_hold = longint'($urandom_range(0, 5));
            for (int i = 0; i < 40; i++) begin
                drive($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 199) == 0);
            end
        end
        drive(1'b0, 16'h0, 1'b0);

        n = 0;
        while (exp_q.size() > 0 && n < 20) begin @(posedge clk); n++; end
        #3;
        chk("drain", longint'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
